// File: rtl/usr_ctrl_pkg.sv
// Shared types and constants for the USR command sequencer.
// Build option: USR_CTRL_ROTATE_EN enables op 11 as ROTATE.
package usr_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_UP     = 2'b01,
    OP_DN     = 2'b10,
    OP_ROTATE = 2'b11
  } op_e;

  localparam logic [1:0] M_LOAD = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DN   = 2'b10;
  localparam logic [1:0] M_HOLD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  // Op 11 is only meaningful when the rotate feature is built in.
  function automatic logic op_legal(input op_e op);
`ifdef USR_CTRL_ROTATE_EN
    op_legal = (op == op);
`else
    op_legal = (op != OP_ROTATE);
`endif
  endfunction

endpackage

// File: rtl/usr_shift_ctrl_if.sv
// Command, serial-in and serial-out streams of the USR sequencer.
// Build option: USR_CTRL_ROTATE_EN (no effect on this interface).
interface usr_shift_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic [WIDTH-1:0] cmd_data;

  logic             sin_valid;
  logic             sin_data;
  logic             sin_ready;

  logic             sout_valid;
  logic             sout_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_len,
    output cmd_data,
    output sin_valid,
    output sin_data,
    input  cmd_ready,
    input  sin_ready,
    input  sout_valid,
    input  sout_data
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_len,
    input  cmd_data,
    input  sin_valid,
    input  sin_data,
    output cmd_ready,
    output sin_ready,
    output sout_valid,
    output sout_data
  );

endinterface

// File: rtl/usr_shift_ctrl_cnt.sv
// Loadable down-counter of remaining shift steps.
// Build option: USR_CTRL_ROTATE_EN (no effect on this module).
module usr_shift_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_d;

  // Next count: reload on accept, step down per shift, never wrap.
  always_comb begin
    rem_d = rem_q;
    if (load_i) begin
      rem_d = len_i;
    end else if (dec_i && (rem_q != '0)) begin
      rem_d = rem_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign last_o = (rem_q == CNT_W'(1));

endmodule

// File: rtl/usr_shift_ctrl.sv
// Command sequencer for an 8-bit universal shift register.
// Build option: USR_CTRL_ROTATE_EN makes op 11 a rotate, else illegal.
module usr_shift_ctrl
  import usr_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  usr_shift_ctrl_if.slave  bus,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       usr_s,
  output logic [WIDTH-1:0] usr_i,
  output logic             usr_ser_lo,
  output logic             usr_ser_hi,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic             err_q;

  logic             accept;
  op_e              cmd_op;
  logic             step;
  logic             last;
  logic             sin_rdy;
  logic             so_vld;
  logic             so_dat;
  logic [1:0]       mode;
  logic             ser_lo;
  logic             ser_hi;

  assign cmd_op = op_e'(bus.cmd_op);
  assign accept = bus.cmd_valid && (state_q == S_IDLE);

  usr_shift_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept),
    .len_i  (bus.cmd_len),
    .dec_i  (step),
    .last_o (last)
  );

  // USR pin decode from state, op and this cycle's serial-in offer.
  always_comb begin
    mode    = M_HOLD;
    ser_lo  = 1'b0;
    ser_hi  = 1'b0;
    so_vld  = 1'b0;
    so_dat  = 1'b0;
    sin_rdy = 1'b0;
    step    = 1'b0;
    if (state_q == S_LOAD) begin
      mode = M_LOAD;
    end
    if (state_q == S_SHIFT) begin
      unique case (1'b1)
        (op_q == OP_UP): begin
          sin_rdy = 1'b1;
          if (bus.sin_valid) begin
            step   = 1'b1;
            mode   = M_UP;
            ser_lo = bus.sin_data;
            so_vld = 1'b1;
            so_dat = usr_q[WIDTH-1];
          end
        end
        (op_q == OP_DN): begin
          sin_rdy = 1'b1;
          if (bus.sin_valid) begin
            step   = 1'b1;
            mode   = M_DN;
            ser_hi = bus.sin_data;
            so_vld = 1'b1;
            so_dat = usr_q[0];
          end
        end
`ifdef USR_CTRL_ROTATE_EN
        (op_q == OP_ROTATE): begin
          step   = 1'b1;
          mode   = M_UP;
          ser_lo = usr_q[WIDTH-1];
          so_vld = 1'b1;
          so_dat = usr_q[WIDTH-1];
        end
`endif
        default: begin
          step = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, captured command and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= cmd_op;
            data_q <= bus.cmd_data;
            err_q  <= 1'b0;
            if (cmd_op == OP_LOAD) begin
              state_q <= S_LOAD;
            end else if (!op_legal(cmd_op)) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else if (bus.cmd_len == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_SHIFT;
            end
          end
        end
        S_LOAD: begin
          state_q <= S_DONE;
        end
        S_SHIFT: begin
          if (step && last) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign usr_s          = mode;
  assign usr_i          = data_q;
  assign usr_ser_lo     = ser_lo;
  assign usr_ser_hi     = ser_hi;
  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.sin_ready  = sin_rdy;
  assign bus.sout_valid = so_vld;
  assign bus.sout_data  = so_dat;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err            = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Self-checking bench for usr_shift_ctrl with a USR device model.
// Build option: USR_CTRL_ROTATE_EN selects rotate expectations.
module tb_usr_shift_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] usr;
  logic [1:0] usr_s;
  logic [7:0] usr_i;
  logic       ser_lo;
  logic       ser_hi;
  logic       busy;
  logic       done;
  logic       err;

  usr_shift_ctrl_if #(.WIDTH(8), .CNT_W(4)) bus ();

  usr_shift_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .usr_q      (usr),
    .usr_s      (usr_s),
    .usr_i      (usr_i),
    .usr_ser_lo (ser_lo),
    .usr_ser_hi (ser_hi),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Universal shift register device model.
  always @(posedge clk) begin
    case (usr_s)
      2'b00: usr <= usr_i;
      2'b01: usr <= {usr[6:0], ser_lo};
      2'b10: usr <= {ser_hi, usr[7:1]};
      default: usr <= usr;
    endcase
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int err_cnt = 0;
  int load_cnt = 0;
  int bad_rdy = 0;
  int stall_hold = 0;
  int n_loads = 0;
  bit sin_q[$];
  bit sout_q[$];
  bit exp_q[$];

  // Monitor: samples pre-edge values of all DUT outputs.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.cmd_valid && bus.cmd_ready) begin
      acc_cnt = acc_cnt + 1;
      acc_cyc = cyc;
    end
    if (bus.sout_valid) sout_q.push_back(bus.sout_data);
    if (bus.sin_valid && bus.sin_ready) sin_q.push_back(bus.sin_data);
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (err) err_cnt = err_cnt + 1;
    if (!reset && usr_s == 2'b00) load_cnt = load_cnt + 1;
    if (busy && bus.cmd_ready) bad_rdy = bad_rdy + 1;
    if (busy && bus.sin_ready && !bus.sin_valid &&
        usr_s == 2'b11 && !bus.sout_valid)
      stall_hold = stall_hold + 1;
  end

  bit          rnd_sin = 0;
  logic [31:0] vmask = '1;
  logic [15:0] sin_bits = '0;
  int          start_cyc = 0;

  // Serial-in producer: scripted valid mask or random offers.
  always @(negedge clk) begin : drv
    int idx;
    int j;
    idx = cyc - start_cyc;
    j = sin_q.size();
    if (rnd_sin) begin
      bus.sin_valid = ($urandom % 4) != 0;
      bus.sin_data  = 1'($urandom % 2);
    end else begin
      bus.sin_valid = (idx < 0 || idx > 31) ? 1'b1 : vmask[idx];
      bus.sin_data  = (j < 16) ? sin_bits[j] : 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic [15:0] pack_q(input int n);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < n && i < 16; i++) p[i] = sout_q[i];
    return p;
  endfunction

  // Reference: USR contents viewed as a bit stream passing through.
  function automatic void ref_model(input logic [1:0] op, input int len,
                                    input logic [7:0] d,
                                    input logic [7:0] st,
                                    output logic [7:0] fin,
                                    output int e);
    bit s[$];
    int m;
    exp_q.delete();
    fin = st;
    e = 0;
    case (op)
      2'd0: fin = d;
      2'd1, 2'd2: begin
        for (int i = 0; i < 8; i++)
          s.push_back(op == 2'd1 ? st[7-i] : st[i]);
        foreach (sin_q[i]) s.push_back(sin_q[i]);
        while (s.size() < len + 8) s.push_back(1'b0);
        for (int i = 0; i < len; i++) exp_q.push_back(s[i]);
        for (int k = 0; k < 8; k++) begin
          if (op == 2'd1) fin[7-k] = s[len+k];
          else fin[k] = s[len+k];
        end
      end
      default: begin
`ifdef USR_CTRL_ROTATE_EN
        m = len % 8;
        fin = 8'((st << m) | (st >> (8 - m)));
        for (int i = 0; i < len; i++) exp_q.push_back(st[7-(i%8)]);
`else
        m = 0;
        e = 1;
`endif
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [3:0] len,
                       input logic [7:0] d, output logic [7:0] st);
    int a0;
    bit ok;
    @(negedge clk);
    st = usr;
    sin_q.delete();
    sout_q.delete();
    a0 = acc_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_len = len;
    bus.cmd_data = d;
    start_cyc = cyc + 1;
    if (op == 2'd0) n_loads = n_loads + 1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != a0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL accept_timeout got 0 want 1");
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] len,
                         input logic [7:0] d, output int lat,
                         output int nd, output int ne,
                         output logic [7:0] st);
    int d0;
    int e0;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    issue(op, len, d, st);
    ok = 0;
    for (int k = 0; k < 80; k++) begin
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL done_timeout got 0 want 1");
    end
    repeat (2) @(posedge clk);
    #1;
    lat = done_cyc - acc_cyc;
    nd = done_cnt - d0;
    ne = err_cnt - e0;
  endtask

  typedef struct {
    logic [7:0]  pre;
    logic [1:0]  op;
    logic [3:0]  len;
    logic [7:0]  d;
    logic [15:0] sin;
    logic [7:0]  x_usr;
    int          x_nout;
    logic [15:0] x_out;
    int          x_lat;
    int          x_err;
  } vec_t;

  vec_t vt[9];

  initial begin
    int lat;
    int nd;
    int ne;
    int xe;
    int d0;
    int h0;
    logic [7:0] st;
    logic [7:0] xu;
    logic [1:0] rop;
    logic [3:0] rlen;
    logic [7:0] rd;

    vt[0] = '{8'h00, 2'd0, 4'd5,  8'hA5, 16'h0000, 8'hA5, 0, 16'h0, 2, 0};
    vt[1] = '{8'hA5, 2'd1, 4'd3,  8'h00, 16'h0005, 8'h2D, 3, 16'h5, 4, 0};
    vt[2] = '{8'hA5, 2'd2, 4'd2,  8'h00, 16'h0003, 8'hE9, 2, 16'h1, 3, 0};
    vt[3] = '{8'h3C, 2'd1, 4'd0,  8'h77, 16'hFFFF, 8'h3C, 0, 16'h0, 1, 0};
    vt[4] = '{8'h0F, 2'd2, 4'd4,  8'h00, 16'h0000, 8'h00, 4, 16'hF, 5, 0};
    vt[5] = '{8'h01, 2'd1, 4'd15, 8'h00, 16'h7FFF, 8'hFF, 15, 16'h7F80, 16, 0};
    vt[6] = '{8'h80, 2'd1, 4'd1,  8'h00, 16'h0001, 8'h01, 1, 16'h1, 2, 0};
`ifdef USR_CTRL_ROTATE_EN
    vt[7] = '{8'h81, 2'd3, 4'd8,  8'h00, 16'h0000, 8'h81, 8, 16'h81, 9, 0};
    vt[8] = '{8'h96, 2'd3, 4'd3,  8'h00, 16'h0000, 8'hB4, 3, 16'h1, 4, 0};
`else
    vt[7] = '{8'h81, 2'd3, 4'd8,  8'h00, 16'h0000, 8'h81, 0, 16'h0, 1, 1};
    vt[8] = '{8'h96, 2'd3, 4'd3,  8'h00, 16'h0000, 8'h96, 0, 16'h0, 1, 1};
`endif

    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_len = 4'd0;
    bus.cmd_data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_usr_s", 32'(usr_s), 32'h3);
    chk("rst_usr_i", 32'(usr_i), 32'h0);
    chk("rst_ser", 32'({ser_hi, ser_lo}), 32'h0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("rst_sin_ready", 32'(bus.sin_ready), 32'h0);
    chk("rst_sout_valid", 32'(bus.sout_valid), 32'h0);
    chk("rst_busy_done_err", 32'({busy, done, err}), 32'h0);

    rnd_sin = 0;
    vmask = '1;
    foreach (vt[i]) begin
      sin_bits = vt[i].sin;
      run_cmd(2'd0, 4'd0, vt[i].pre, lat, nd, ne, st);
      run_cmd(vt[i].op, vt[i].len, vt[i].d, lat, nd, ne, st);
      chk($sformatf("v%0d_usr", i), 32'(usr), 32'(vt[i].x_usr));
      chk($sformatf("v%0d_nout", i), sout_q.size(), vt[i].x_nout);
      chk($sformatf("v%0d_out", i), 32'(pack_q(sout_q.size())),
          32'(vt[i].x_out));
      chk($sformatf("v%0d_lat", i), lat, vt[i].x_lat);
      chk($sformatf("v%0d_ndone", i), nd, 1);
      chk($sformatf("v%0d_err", i), ne, vt[i].x_err);
    end

    // Stall: SHIFT_DN len 2, sin_valid low for two cycles after step 1.
    sin_bits = 16'h0002;
    run_cmd(2'd0, 4'd0, 8'h5A, lat, nd, ne, st);
    vmask = 32'hFFFF_FFF9;
    h0 = stall_hold;
    run_cmd(2'd2, 4'd2, 8'h00, lat, nd, ne, st);
    chk("stall_hold_cycles", stall_hold - h0, 2);
    chk("stall_steps", sin_q.size(), 2);
    chk("stall_usr", 32'(usr), 32'h96);
    chk("stall_out", 32'(pack_q(sout_q.size())), 32'h2);
    chk("stall_nout", sout_q.size(), 2);
    chk("stall_lat", lat, 5);
    chk("stall_ndone", nd, 1);
    vmask = '1;

    // Reset during step 2 of a 5-step SHIFT_UP.
    sin_bits = 16'hFFFF;
    d0 = done_cnt;
    xe = err_cnt;
    issue(2'd1, 4'd5, 8'h00, st);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_no_err", err_cnt - xe, 0);

    // Random commands against the stream reference model.
    rnd_sin = 1;
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom % 4);
      rlen = 4'($urandom % 16);
      rd = 8'($urandom);
      run_cmd(rop, rlen, rd, lat, nd, ne, st);
      ref_model(rop, int'(rlen), rd, st, xu, xe);
      chk($sformatf("r%0d_usr", n), 32'(usr), 32'(xu));
      chk($sformatf("r%0d_nout", n), sout_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < sout_q.size(); i++)
        chk($sformatf("r%0d_out%0d", n, i), 32'(sout_q[i]), 32'(exp_q[i]));
      chk($sformatf("r%0d_ndone", n), nd, 1);
      chk($sformatf("r%0d_err", n), ne, xe);
      if (rop == 2'd0)
        chk($sformatf("r%0d_lat", n), lat, 2);
      else if (xe == 1 || rlen == 4'd0)
        chk($sformatf("r%0d_lat", n), lat, 1);
      else if (rop == 2'd3)
        chk($sformatf("r%0d_lat", n), lat, int'(rlen) + 1);
      else
        chk($sformatf("r%0d_lat_min", n), 32'(lat >= int'(rlen) + 1), 32'h1);
      if ((rop == 2'd1 || rop == 2'd2) && rlen != 4'd0)
        chk($sformatf("r%0d_sin_cnt", n), sin_q.size(), int'(rlen));
    end

    chk("load_cycles", load_cnt, n_loads);
    chk("ready_while_busy", bad_rdy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
